// File: rtl/pp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pp_pkg
//  Description : Shared definitions for the 5-stage pipeline hazard control:
//                opcode constants, hazard FSM state type, forwarding select
//                encodings and the forwarding priority helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pp_pkg;

    // Instr[31:26] values that affect source-register usage
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Hazard sequencing states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // EX operand source selects
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Select the freshest producer for one EX source register. The EX/MEM
    // result is younger than MEM/WB, so it takes priority. Register 0 is
    // hard-wired and is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_dst,
        input logic       mem_we,
        input logic [4:0] wb_dst,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != 5'd0) begin
            if (mem_we && (mem_dst == src)) begin
                sel = FWD_EXMEM;
            end else if (wb_we && (wb_dst == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage : pp_pkg
`default_nettype wire

// File: rtl/fwd_unit_pp.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_unit_pp
//  Description : Operand forwarding selects for the EX stage.
//                Inputs : ex_rs, ex_rt (EX sources), mem_dst/mem_reg_write,
//                         wb_dst/wb_reg_write (later-stage producers)
//                Outputs: fwd_a, fwd_b (00 regfile, 10 EX/MEM, 01 MEM/WB)
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_unit_pp
    import pp_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_dst,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_dst,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_dst, mem_reg_write, wb_dst, wb_reg_write);
        fwd_b = fwd_sel(ex_rt, mem_dst, mem_reg_write, wb_dst, wb_reg_write);
    end

endmodule : fwd_unit_pp
`default_nettype wire

// File: rtl/hazard_ctrl_pp.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pp
//  Description : Hazard and sequencing controller for a 5-stage MIPS pipeline.
//                Detects RAW hazards between the ID instruction and the EX/MEM
//                producers, stalls PC and IF/ID while inserting ID/EX bubbles,
//                flushes wrong-path fetches on taken branches and jumps, and
//                counts stall / flush cycles with saturating counters.
//  Config      : HAZARD_FWD_EN - when defined, operands are forwarded and only
//                load-use stalls one cycle; when undefined, no forwarding and
//                EX/MEM producers stall two/one cycles.
//  Ports       : clk, rst_n (sync, active-low)
//                id_opcode/id_rs/id_rt       - decoded ID fields
//                ex_rs/ex_rt/ex_dst/ex_reg_write/ex_mem_read - EX stage
//                mem_dst/mem_reg_write, wb_dst/wb_reg_write  - MEM/WB stage
//                branch_taken                - branch resolved taken in EX
//                pc_write, if_id_write, if_id_flush, id_ex_bubble - controls
//                fwd_a, fwd_b                - EX operand selects
//                stall_cnt, flush_cnt        - performance counters
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl_pp
    import pp_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_dst,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_dst,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_dst,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_stall_left;
    logic [1:0]       w_stall_left_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // ------------------------------------------------------------------------
    // Source usage decode. Register 0 can never carry a dependency.
    // ------------------------------------------------------------------------
    logic w_is_jump;
    logic w_use_rs;
    logic w_use_rt;

    always_comb begin
        w_is_jump = (id_opcode == OP_J) || (id_opcode == OP_JAL);
        w_use_rs  = !w_is_jump && (id_rs != 5'd0);
        w_use_rt  = ((id_opcode == OP_RTYPE) || (id_opcode == OP_BEQ) ||
                     (id_opcode == OP_BNE)   || (id_opcode == OP_SW)) &&
                    (id_rt != 5'd0);
    end

    // ------------------------------------------------------------------------
    // Stall need (number of bubble cycles required by the ID instruction).
    // WB producers never hazard: the register file writes before it reads.
    // ------------------------------------------------------------------------
    logic [1:0] w_need;

`ifdef HAZARD_FWD_EN
    logic w_unused;

    // With forwarding only a load result is too late for the next EX stage.
    always_comb begin
        w_need = 2'd0;
        if (ex_mem_read && ((w_use_rs && (ex_dst == id_rs)) ||
                            (w_use_rt && (ex_dst == id_rt)))) begin
            w_need = 2'd1;
        end
    end

    fwd_unit_pp u_fwd (
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_dst       (mem_dst),
        .mem_reg_write (mem_reg_write),
        .wb_dst        (wb_dst),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    assign w_unused = ex_reg_write;
`else
    logic [1:0] w_need_rs;
    logic [1:0] w_need_rt;
    logic       w_unused;

    // Without forwarding a producer in EX is two writes away from the
    // register file, a producer in MEM one; the worse source decides.
    always_comb begin
        w_need_rs = 2'd0;
        w_need_rt = 2'd0;
        if (w_use_rs) begin
            if (ex_reg_write && (ex_dst == id_rs)) begin
                w_need_rs = 2'd2;
            end else if (mem_reg_write && (mem_dst == id_rs)) begin
                w_need_rs = 2'd1;
            end
        end
        if (w_use_rt) begin
            if (ex_reg_write && (ex_dst == id_rt)) begin
                w_need_rt = 2'd2;
            end else if (mem_reg_write && (mem_dst == id_rt)) begin
                w_need_rt = 2'd1;
            end
        end
        w_need = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;
    end

    assign fwd_a    = FWD_REG;
    assign fwd_b    = FWD_REG;
    assign w_unused = ^{ex_rs, ex_rt, wb_dst, wb_reg_write, ex_mem_read};
`endif

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_stall_left <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_stall_left <= w_stall_left_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and Mealy outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_stall_left_nxt = r_stall_left;
        pc_write         = 1'b1;
        if_id_write      = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_bubble     = 1'b0;

        if (branch_taken) begin
            // Squash the wrong-path instructions in IF/ID and ID/EX and let
            // the PC load the target; any pending stall is moot.
            if_id_flush      = 1'b1;
            id_ex_bubble     = 1'b1;
            w_stall_left_nxt = 2'd0;
            w_state_nxt      = ST_FLUSH;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_need != 2'd0) begin
                        pc_write         = 1'b0;
                        if_id_write      = 1'b0;
                        id_ex_bubble     = 1'b1;
                        w_stall_left_nxt = w_need - 2'd1;
                        w_state_nxt      = (w_need > 2'd1) ? ST_STALL : ST_RUN;
                    end else if (w_is_jump) begin
                        // The fetch behind a jump is on the wrong path.
                        if_id_flush = 1'b1;
                    end
                end
                ST_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (r_stall_left <= 2'd1) begin
                        w_stall_left_nxt = 2'd0;
                        w_state_nxt      = ST_RUN;
                    end else begin
                        w_stall_left_nxt = r_stall_left - 2'd1;
                    end
                end
                ST_FLUSH: begin
                    // Second wrong-path fetch after the taken branch.
                    if_id_flush = 1'b1;
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_stall_left_nxt = 2'd0;
                    w_state_nxt      = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (id_ex_bubble && !branch_taken && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule : hazard_ctrl_pp
`default_nettype wire

// File: tb/tb_hazard_ctrl_pp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl_pp
//  Description : Directed self-checking bench for hazard_ctrl_pp. Expected
//                values are hand-derived for both HAZARD_FWD_EN settings.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_pp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic        ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
    logic        branch_taken;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl_pp #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_opcode     (id_opcode),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_dst        (ex_dst),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .mem_dst       (mem_dst),
        .mem_reg_write (mem_reg_write),
        .wb_dst        (wb_dst),
        .wb_reg_write  (wb_reg_write),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control outputs packed {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, {28'd0, exp});
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall_cnt"}, stall_cnt, exp_stall);
        chk({tag, "_flush_cnt"}, flush_cnt, exp_flush);
    endtask

    // Advance to just after the next rising edge, then drive new inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point in the middle of the cycle.
    task automatic samp();
        @(negedge clk);
    endtask

    task automatic idle();
        id_opcode = 6'h00; id_rs = 5'd0; id_rt = 5'd0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_dst = 5'd0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_dst = 5'd0; mem_reg_write = 1'b0;
        wb_dst = 5'd0; wb_reg_write = 1'b0;
        branch_taken = 1'b0;
    endtask

    localparam logic [3:0] CTL_RUN   = 4'b1100;
    localparam logic [3:0] CTL_STALL = 4'b0001;
    localparam logic [3:0] CTL_BR    = 4'b1111;
    localparam logic [3:0] CTL_FL    = 4'b1110;

    initial begin
        // ---------------- reset ----------------
        idle();
        rst_n = 1'b0;
        tick(); tick();
        samp();
        chk_ctl("reset_ctl", CTL_RUN);
        chk("reset_fwd", {30'd0, fwd_a}, 32'd0);
        chk_cnt("reset");
        tick();
        rst_n = 1'b1;

        // ---------------- load-use: lw $8 in EX, add rs=8 in ID ----------------
        idle();
        id_rs = 5'd8; ex_dst = 5'd8; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        samp();
        chk_ctl("loaduse_c0", CTL_STALL);
        tick();
        idle();                                     // bubble now in EX, lw in MEM
        mem_dst = 5'd8; mem_reg_write = 1'b1; id_rs = 5'd8;
        samp();
`ifdef HAZARD_FWD_EN
        chk_ctl("loaduse_c1", CTL_RUN);
        exp_stall += 1;
`else
        // load in EX is a 2-cycle producer without forwarding
        chk_ctl("loaduse_c1", CTL_STALL);
        exp_stall += 2;
`endif
        tick();
        idle();
        samp();
        chk_ctl("loaduse_c2", CTL_RUN);
        chk_cnt("loaduse");

        // ---------------- ALU producer in EX: add dst=9, sub rs=9 ----------------
        tick();
        idle();
        id_rs = 5'd9; ex_dst = 5'd9; ex_reg_write = 1'b1;
        samp();
`ifdef HAZARD_FWD_EN
        chk_ctl("exprod_c0", CTL_RUN);
`else
        chk_ctl("exprod_c0", CTL_STALL);
        tick();
        idle();
        id_rs = 5'd9; mem_dst = 5'd9; mem_reg_write = 1'b1;
        samp();
        chk_ctl("exprod_c1", CTL_STALL);
        exp_stall += 2;
`endif
        tick();
        idle();
        samp();
        chk_ctl("exprod_end", CTL_RUN);
        chk_cnt("exprod");

        // ---------------- producer in MEM only, via rt of beq ----------------
        tick();
        idle();
        id_opcode = 6'h04; id_rt = 5'd9; mem_dst = 5'd9; mem_reg_write = 1'b1;
        samp();
`ifdef HAZARD_FWD_EN
        chk_ctl("memprod_c0", CTL_RUN);
`else
        chk_ctl("memprod_c0", CTL_STALL);
        exp_stall += 1;
`endif
        tick();
        idle();
        samp();
        chk_ctl("memprod_end", CTL_RUN);
        chk_cnt("memprod");

        // ---------------- rt not used by lw; reg0 never hazards ----------------
        tick();
        idle();
        id_opcode = 6'h23; id_rt = 5'd9;
        ex_dst = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        samp();
        chk_ctl("lw_rt_unused", CTL_RUN);
        tick();
        idle();
        ex_dst = 5'd0; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        mem_reg_write = 1'b1;
        samp();
        chk_ctl("reg0_nohaz", CTL_RUN);

        // ---------------- forwarding selects ----------------
        tick();
        idle();
        ex_rs = 5'd5; ex_rt = 5'd6;
        mem_dst = 5'd5; mem_reg_write = 1'b1;
        wb_dst = 5'd5; wb_reg_write = 1'b1;
        samp();
`ifdef HAZARD_FWD_EN
        chk("fwd_a_exmem", {30'd0, fwd_a}, 32'd2);
`else
        chk("fwd_a_off", {30'd0, fwd_a}, 32'd0);
`endif
        chk("fwd_b_none", {30'd0, fwd_b}, 32'd0);
        tick();
        mem_reg_write = 1'b0; wb_dst = 5'd6;
        ex_rs = 5'd6;
        samp();
`ifdef HAZARD_FWD_EN
        chk("fwd_a_memwb", {30'd0, fwd_a}, 32'd1);
        chk("fwd_b_memwb", {30'd0, fwd_b}, 32'd1);
`else
        chk("fwd_b_off", {30'd0, fwd_b}, 32'd0);
`endif
        tick();
        ex_rs = 5'd0; wb_dst = 5'd0;
        samp();
        chk("fwd_a_reg0", {30'd0, fwd_a}, 32'd0);

        // ---------------- taken branch during a stall ----------------
        tick();
        idle();
        id_rs = 5'd9; ex_dst = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        samp();
        chk_ctl("br_stall_c0", CTL_STALL);
        exp_stall += 1;
        tick();
        idle();
        branch_taken = 1'b1;
        samp();
        chk_ctl("br_taken", CTL_BR);
        exp_flush += 1;
        tick();
        idle();
        samp();
        chk_ctl("br_flush", CTL_FL);
        exp_flush += 1;
        tick();
        idle();
        samp();
        chk_ctl("br_after", CTL_RUN);
        chk_cnt("branch");

        // ---------------- jump: j with rs that would otherwise hazard ----------------
        tick();
        idle();
        id_opcode = 6'h02; id_rs = 5'd9;
        ex_dst = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        samp();
        chk_ctl("jump", CTL_FL);
        exp_flush += 1;
        tick();
        idle();
        samp();
        chk_ctl("jump_after", CTL_RUN);
        chk_cnt("jump");

        // ---------------- reset while stalled ----------------
        tick();
        idle();
        id_rs = 5'd9; ex_dst = 5'd9; ex_reg_write = 1'b1;
        ex_mem_read = 1'b1;
        samp();
        chk_ctl("rst_stall_c0", CTL_STALL);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        samp();
        chk_ctl("rst_mid_ctl", CTL_RUN);
        chk_cnt("rst_mid");
        tick();
        samp();
        chk_ctl("rst_mid_after", CTL_RUN);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_hazard_ctrl_pp
`default_nettype wire
